key_msg_sender: RTL and testbench

- Downstream consumer of the debounced key pulse (`key_flag`).
- Each accepted press transmits a fixed 10-byte ASCII message, "20001029" followed by CR LF, one byte at a time.
- Bytes go over a valid/ready byte stream into the UART transmitter.
- Presses that arrive while a message is in flight are queued one deep, and a programmable idle gap separates consecutive messages.

---
 rtl/key_msg_sender_if.sv | 19 +
 rtl/key_msg_sender.sv | 140 ++++++++++++++
 tb/tb_key_msg_sender.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/key_msg_sender_if.sv
// Byte stream from the message sender to the UART transmitter.
// A byte moves on every cycle where tx_valid and tx_ready are both high.
interface key_msg_sender_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;

   modport master (
      output tx_valid,
      output tx_data,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_data,
      output tx_ready
   );
endinterface

// File: rtl/key_msg_sender.sv
// Sends "20001029\r\n" over a byte stream on every accepted key press.
// One press can wait while a message is in flight, and an idle gap separates messages.
module key_msg_sender #(
   parameter int GAP_CYCLES = 16,
   parameter int MSG_LEN    = 10
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    key_flag,
   key_msg_sender_if.master        tx,
   output logic                    busy,
   output logic                    done,
   output logic [7:0]              msg_cnt
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

   localparam logic [3:0]  LAST_IDX = 4'(MSG_LEN - 1);
   localparam logic [15:0] GAP_LAST =
      16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   function automatic logic [7:0] rom(input logic [3:0] i);
      logic [7:0] b;
      case (i)
         4'd0:    b = 8'h32;
         4'd1:    b = 8'h30;
         4'd2:    b = 8'h30;
         4'd3:    b = 8'h30;
         4'd4:    b = 8'h31;
         4'd5:    b = 8'h30;
         4'd6:    b = 8'h32;
         4'd7:    b = 8'h39;
         4'd8:    b = 8'h0D;
         4'd9:    b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [15:0] gap_q, gap_d;
   logic        pend_q, pend_d;
   logic        valid_q, valid_d;
   logic [7:0]  data_q, data_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        hs;
   logic        gap_exit;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      gap_d    = gap_q;
      pend_d   = pend_q;
      valid_d  = valid_q;
      data_d   = data_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      hs       = valid_q & tx.tx_ready;
      gap_exit = (GAP_CYCLES == 0) || (gap_q == GAP_LAST);
      unique case (state_q)
         IDLE: begin
            if (key_flag) begin
               state_d = SEND;
               idx_d   = 4'd0;
               valid_d = 1'b1;
               data_d  = rom(4'd0);
            end
         end
         SEND: begin
            if (key_flag) pend_d = 1'b1;
            if (hs) begin
               if (idx_q == LAST_IDX) begin
                  state_d = GAP;
                  gap_d   = 16'd0;
                  valid_d = 1'b0;
                  data_d  = 8'h00;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
               end else begin
                  idx_d  = idx_q + 4'd1;
                  data_d = rom(idx_q + 4'd1);
               end
            end
         end
         GAP: begin
            // A queued press wins; a press arriving on the exit cycle is then dropped
            if (gap_exit) begin
               if (pend_q || key_flag) begin
                  state_d = SEND;
                  pend_d  = 1'b0;
                  idx_d   = 4'd0;
                  valid_d = 1'b1;
                  data_d  = rom(4'd0);
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_d = gap_q + 16'd1;
               if (key_flag) pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 4'd0;
         gap_q   <= 16'd0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= 8'h00;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         pend_q  <= pend_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign tx.tx_valid = valid_q;
   assign tx.tx_data  = data_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign msg_cnt     = cnt_q;

endmodule

// File: tb/tb_key_msg_sender.sv
// Directed bench for key_msg_sender: default gap on u_a, zero gap on u_b.
// Expected bytes and cycle timings are hand-derived constants.
module tb_key_msg_sender;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       key_a, key_b;
   logic       busy_a, done_a, busy_b, done_b;
   logic [7:0] cnt_a, cnt_b;

   key_msg_sender_if ifa ();
   key_msg_sender_if ifb ();

   key_msg_sender u_a (
      .clk      (clk),
      .rst      (rst),
      .key_flag (key_a),
      .tx       (ifa),
      .busy     (busy_a),
      .done     (done_a),
      .msg_cnt  (cnt_a)
   );

   key_msg_sender #(.GAP_CYCLES(0)) u_b (
      .clk      (clk),
      .rst      (rst),
      .key_flag (key_b),
      .tx       (ifb),
      .busy     (busy_b),
      .done     (done_b),
      .msg_cnt  (cnt_b)
   );

   int checks = 0;
   int fails  = 0;

   logic [7:0] rom [10] = '{8'h32, 8'h30, 8'h30, 8'h30, 8'h31,
                            8'h30, 8'h32, 8'h39, 8'h0D, 8'h0A};
   logic [15:0] pat = 16'b1001_0110_0011_1010;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int hs;
      int n;
      rst = 1'b1;
      key_a = 1'b0;
      key_b = 1'b0;
      ifa.tx_ready = 1'b0;
      ifb.tx_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", ifa.tx_valid, 0);
      chk("rst_data", ifa.tx_data, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_done", done_a, 0);
      chk("rst_cnt", cnt_a, 0);
      step();

      // single press, ready tied high
      ifa.tx_ready = 1'b1;
      key_a = 1'b1;
      step();
      key_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("t1_valid", ifa.tx_valid, 1);
         chk("t1_data", ifa.tx_data, rom[i]);
         step();
      end
      chk("t1_done", done_a, 1);
      chk("t1_valid_off", ifa.tx_valid, 0);
      chk("t1_data_off", ifa.tx_data, 0);
      chk("t1_cnt", cnt_a, 1);
      step();
      chk("t1_done_pulse", done_a, 0);
      repeat (14) step();
      chk("t1_gap_busy", busy_a, 1);
      step();
      chk("t1_idle", busy_a, 0);

      // ready follows a fixed stall pattern
      ifa.tx_ready = 1'b0;
      key_a = 1'b1;
      step();
      key_a = 1'b0;
      hs = 0;
      for (int c = 0; c < 200 && !done_a; c++) begin
         ifa.tx_ready = pat[c % 16];
         if (ifa.tx_valid) begin
            chk("t2_data", ifa.tx_data, rom[(hs < 10) ? hs : 0]);
            if (ifa.tx_ready) hs++;
         end
         step();
      end
      chk("t2_done", done_a, 1);
      chk("t2_hs", hs, 10);
      chk("t2_cnt", cnt_a, 2);
      repeat (16) step();
      chk("t2_idle", busy_a, 0);

      // presses at byte 4 and byte 7: one queued, one dropped
      ifa.tx_ready = 1'b1;
      key_a = 1'b1;
      step();
      key_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_a = (i == 4 || i == 7);
         chk("t3_data1", ifa.tx_data, rom[i]);
         step();
      end
      key_a = 1'b0;
      chk("t3_done1", done_a, 1);
      chk("t3_cnt1", cnt_a, 3);
      repeat (15) step();
      chk("t3_gap", ifa.tx_valid, 0);
      step();
      chk("t3_restart", ifa.tx_valid, 1);
      for (int i = 0; i < 10; i++) begin
         chk("t3_data2", ifa.tx_data, rom[i]);
         step();
      end
      chk("t3_done2", done_a, 1);
      repeat (16) step();
      chk("t3_idle", busy_a, 0);
      chk("t3_cnt2", cnt_a, 4);

      // zero gap, press coincident with last handshake
      ifb.tx_ready = 1'b1;
      key_b = 1'b1;
      step();
      key_b = 1'b0;
      for (int i = 0; i < 10; i++) begin
         key_b = (i == 9);
         chk("t4_data1", ifb.tx_data, rom[i]);
         step();
      end
      key_b = 1'b0;
      chk("t4_done", done_b, 1);
      chk("t4_valid_off", ifb.tx_valid, 0);
      step();
      chk("t4_valid_on", ifb.tx_valid, 1);
      chk("t4_first", ifb.tx_data, 8'h32);
      chk("t4_done_pulse", done_b, 0);
      for (int i = 0; i < 10; i++) begin
         chk("t4_data2", ifb.tx_data, rom[i]);
         step();
      end
      chk("t4_done2", done_b, 1);
      chk("t4_cnt", cnt_b, 2);
      step();
      chk("t4_idle", busy_b, 0);

      // reset during byte 5
      key_a = 1'b1;
      step();
      key_a = 1'b0;
      repeat (5) step();
      chk("t5_byte5", ifa.tx_data, rom[5]);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("t5_valid", ifa.tx_valid, 0);
      chk("t5_busy", busy_a, 0);
      chk("t5_cnt", cnt_a, 0);
      chk("t5_done", done_a, 0);
      rst = 1'b1;
      key_a = 1'b1;
      step();
      rst = 1'b0;
      key_a = 1'b0;
      chk("t5_prio", busy_a, 0);
      key_a = 1'b1;
      step();
      key_a = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk("t5_data", ifa.tx_data, rom[i]);
         step();
      end
      chk("t5_done2", done_a, 1);
      chk("t5_cnt2", cnt_a, 1);

      // 256 back-to-back messages on the zero-gap instance
      key_b = 1'b1;
      n = 0;
      for (int c = 0; c < 4000 && n < 256; c++) begin
         step();
         if (done_b) begin
            n++;
            if (n == 255) chk("t6_cnt255", cnt_b, 255);
            if (n == 256) chk("t6_wrap", cnt_b, 0);
         end
      end
      key_b = 1'b0;
      chk("t6_msgs", n, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
